// File: rtl/eth_fcs_pad.sv
// Ethernet TX tail stage: zero-pads short frames to MIN_FRAME bytes and appends the
// IEEE 802.3 FCS to a 32-bit MSB-lane-first byte stream behind a one-beat output register.
module eth_fcs_pad #(
    parameter int unsigned MIN_FRAME = 60,
    parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_tdata,
    input  logic [3:0]  s_tkeep,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic [3:0]  m_tkeep,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic [15:0] frames_sent
);

    localparam int unsigned CNT_W    = 16;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_SPILL
    } state_t;

    // Reflected CRC-32 over the first nbytes lanes of word, lane [31:24] first.
    function automatic logic [31:0] crc_step(input logic [31:0] crc_in,
                                             input logic [31:0] word,
                                             input logic [2:0]  nbytes);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nbytes) begin
                c = c ^ {24'h0, word[31-8*i -: 8]};
                for (int b = 0; b < 8; b++) begin
                    c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

    // FCS goes out least-significant byte first, i.e. fcs[7:0] in the top lane.
    function automatic logic [31:0] fcs_lanes(input logic [31:0] f);
        return {f[7:0], f[15:8], f[23:16], f[31:24]};
    endfunction

    function automatic logic [3:0] keep_ones(input logic [2:0] k);
        case (k)
            3'd1:    return 4'b1000;
            3'd2:    return 4'b1100;
            3'd3:    return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat16(input logic [CNT_W:0] v);
        return v[CNT_W] ? {CNT_W{1'b1}} : v[CNT_W-1:0];
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_crc;
    logic [31:0]        w_crc_nxt;
    logic [31:0]        w_crc_calc;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]         r_spill_k;
    logic [2:0]         w_spill_k_nxt;

    logic               w_out_free;
    logic               w_in_frame;
    logic               w_accept;
    logic [2:0]         w_k;
    logic [3:0]         w_k_keep;
    logic [31:0]        w_k_mask;
    logic [31:0]        w_data_k;
    logic [31:0]        w_data_pad;
    logic [CNT_W:0]     w_len;
    logic [CNT_W:0]     w_len_up4;
    logic               w_short;

    logic [31:0]        w_feed_word;
    logic [2:0]         w_feed_n;

    logic               w_out_vld;
    logic [31:0]        w_out_data;
    logic [3:0]         w_out_keep;
    logic               w_out_last;

    assign w_out_free = !m_tvalid || m_tready;
    assign w_in_frame = (r_state == ST_IDLE) || (r_state == ST_DATA);
    assign s_tready   = !reset && w_out_free && w_in_frame;
    assign w_accept   = s_tvalid && s_tready;

    // Byte count of the current beat; only the last beat may be partial.
    always_comb begin
        w_k = 3'd4;
        if (s_tlast) begin
            case (s_tkeep)
                4'b1000: w_k = 3'd1;
                4'b1100: w_k = 3'd2;
                4'b1110: w_k = 3'd3;
                default: w_k = 3'd4;
            endcase
        end
    end

    assign w_k_keep   = keep_ones(w_k);
    assign w_k_mask   = {{8{w_k_keep[3]}}, {8{w_k_keep[2]}}, {8{w_k_keep[1]}}, {8{w_k_keep[0]}}};
    assign w_data_k   = s_tdata & w_k_mask;
    assign w_data_pad = w_data_k | ({4{PAD_BYTE}} & ~w_k_mask);
    assign w_len      = {1'b0, r_byte_cnt} + (CNT_W+1)'(w_k);
    assign w_len_up4  = (w_len + (CNT_W+1)'(3)) & ~(CNT_W+1)'(3);
    assign w_short    = w_len < (CNT_W+1)'(MIN_FRAME);

    // Bytes entering the CRC this cycle: kept data lanes, plus pad lanes when padding.
    always_comb begin
        w_feed_word = '0;
        w_feed_n    = '0;
        if (w_accept) begin
            if (!s_tlast) begin
                w_feed_word = s_tdata;
                w_feed_n    = 3'd4;
            end else if (w_short) begin
                w_feed_word = w_data_pad;
                w_feed_n    = 3'd4;
            end else begin
                w_feed_word = s_tdata;
                w_feed_n    = w_k;
            end
        end else if (r_state == ST_PAD && w_out_free) begin
            w_feed_word = {4{PAD_BYTE}};
            w_feed_n    = 3'd4;
        end
    end

    assign w_crc_calc = crc_step(r_crc, w_feed_word, w_feed_n);

    always_comb begin
        w_state_nxt   = r_state;
        w_crc_nxt     = r_crc;
        w_cnt_nxt     = r_byte_cnt;
        w_spill_k_nxt = r_spill_k;
        w_out_vld     = 1'b0;
        w_out_data    = '0;
        w_out_keep    = '0;
        w_out_last    = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DATA: begin
                if (w_accept) begin
                    w_out_vld  = 1'b1;
                    w_out_keep = 4'b1111;
                    w_crc_nxt  = w_crc_calc;
                    if (!s_tlast) begin
                        w_out_data  = s_tdata;
                        w_cnt_nxt   = sat16({1'b0, r_byte_cnt} + (CNT_W+1)'(4));
                        w_state_nxt = ST_DATA;
                    end else if (w_short) begin
                        w_out_data  = w_data_pad;
                        w_cnt_nxt   = w_len_up4[CNT_W-1:0];
                        w_state_nxt = (w_len_up4 < (CNT_W+1)'(MIN_FRAME)) ? ST_PAD : ST_FCS;
                    end else if (w_k == 3'd4) begin
                        w_out_data  = s_tdata;
                        w_cnt_nxt   = sat16(w_len);
                        w_state_nxt = ST_FCS;
                    end else begin
                        // Partial last word: leading FCS bytes fill the unused lanes.
                        w_out_data    = w_data_k | (fcs_lanes(~w_crc_calc) >> {w_k, 3'b000});
                        w_cnt_nxt     = sat16(w_len);
                        w_spill_k_nxt = w_k;
                        w_state_nxt   = ST_SPILL;
                    end
                end
            end
            ST_PAD: begin
                if (w_out_free) begin
                    w_out_vld  = 1'b1;
                    w_out_keep = 4'b1111;
                    w_out_data = {4{PAD_BYTE}};
                    w_crc_nxt  = w_crc_calc;
                    w_cnt_nxt  = r_byte_cnt + CNT_W'(4);
                    if ({1'b0, r_byte_cnt} + (CNT_W+1)'(4) >= (CNT_W+1)'(MIN_FRAME)) begin
                        w_state_nxt = ST_FCS;
                    end
                end
            end
            ST_FCS: begin
                if (w_out_free) begin
                    w_out_vld   = 1'b1;
                    w_out_keep  = 4'b1111;
                    w_out_last  = 1'b1;
                    w_out_data  = fcs_lanes(~r_crc);
                    w_crc_nxt   = CRC_INIT;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SPILL: begin
                if (w_out_free) begin
                    w_out_vld   = 1'b1;
                    w_out_keep  = keep_ones(r_spill_k);
                    w_out_last  = 1'b1;
                    w_out_data  = fcs_lanes(~r_crc) << {3'(3'd4 - r_spill_k), 3'b000};
                    w_crc_nxt   = CRC_INIT;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_crc       <= CRC_INIT;
            r_byte_cnt  <= '0;
            r_spill_k   <= '0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tkeep     <= '0;
            m_tlast     <= 1'b0;
            frames_sent <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_crc      <= w_crc_nxt;
            r_byte_cnt <= w_cnt_nxt;
            r_spill_k  <= w_spill_k_nxt;
            if (w_out_free) begin
                m_tvalid <= w_out_vld;
                m_tdata  <= w_out_data;
                m_tkeep  <= w_out_keep;
                m_tlast  <= w_out_last;
            end
            if (m_tvalid && m_tready && m_tlast) begin
                frames_sent <= frames_sent + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_fcs_pad.sv
// Directed bench for eth_fcs_pad: padding, FCS placement, spill, backpressure and reset.
module tb_eth_fcs_pad;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [15:0] frames_sent;

    logic [31:0] s8_tdata;
    logic [3:0]  s8_tkeep;
    logic        s8_tvalid;
    logic        s8_tlast;
    logic        s8_tready;
    logic [31:0] m8_tdata;
    logic [3:0]  m8_tkeep;
    logic        m8_tvalid;
    logic        m8_tlast;
    logic        m8_tready;
    logic [15:0] frames8_sent;

    eth_fcs_pad dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready), .frames_sent(frames_sent)
    );

    eth_fcs_pad #(.MIN_FRAME(8), .PAD_BYTE(8'h00)) dut8 (
        .clk(clk), .reset(reset),
        .s_tdata(s8_tdata), .s_tkeep(s8_tkeep), .s_tvalid(s8_tvalid), .s_tlast(s8_tlast),
        .s_tready(s8_tready),
        .m_tdata(m8_tdata), .m_tkeep(m8_tkeep), .m_tvalid(m8_tvalid), .m_tlast(m8_tlast),
        .m_tready(m8_tready), .frames_sent(frames8_sent)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [36:0] out_q[$];
    logic [36:0] out8_q[$];
    logic [36:0] exp_q[$];
    logic [7:0]  frame_q[$];
    bit          bp_en = 1'b0;
    bit          stall_prev = 1'b0;
    bit          rdy_seen = 1'b0;
    logic [37:0] hold_prev = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        rdy_seen = s_tready;
        if (!reset) begin
            if (stall_prev) begin
                check_eq("stall_hold", 64'({m_tvalid, m_tlast, m_tkeep, m_tdata}), 64'(hold_prev));
            end
            if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tkeep, m_tdata});
            if (m8_tvalid && m8_tready) out8_q.push_back({m8_tlast, m8_tkeep, m8_tdata});
            stall_prev = m_tvalid && !m_tready;
            hold_prev  = {m_tvalid, m_tlast, m_tkeep, m_tdata};
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n        = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        do begin
            tick();
            n++;
        end while (!rdy_seen && n < 300);
        if (!rdy_seen) check_eq("s_tready_timeout", 64'(rdy_seen), 64'(1));
        s_tvalid = 1'b0;
    endtask

    task automatic make_frame(input int len, input int seed);
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(8'(i * 7 + seed + 1));
    endtask

    // Unused lanes of the last beat carry 0xEE so masking/padding is exercised.
    task automatic send_frame(input int nbeats);
        int n;
        n = frame_q.size();
        for (int b = 0; b < n && b < nbeats * 4; b += 4) begin
            logic [31:0] d;
            logic [3:0]  k;
            for (int j = 0; j < 4; j++) begin
                d[31-8*j -: 8] = (b + j < n) ? frame_q[b+j] : 8'hEE;
                k[3-j]         = (b + j < n);
            end
            drive_beat(d, (b + 4 >= n) ? k : 4'hF, (b + 4 >= n));
        end
    endtask

    // Reference: pad to min_frame, bit-serial CRC-32, FCS LSB byte first, pack MSB-lane first.
    task automatic build_expected(input int min_frame);
        logic [7:0]  bytes[$];
        logic [31:0] c;
        logic        fb;
        bytes = frame_q;
        while (bytes.size() < min_frame) bytes.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (bytes[x]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ bytes[x][i];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        c = ~c;
        bytes.push_back(c[7:0]);
        bytes.push_back(c[15:8]);
        bytes.push_back(c[23:16]);
        bytes.push_back(c[31:24]);
        for (int b = 0; b < bytes.size(); b += 4) begin
            logic [31:0] d;
            logic [3:0]  k;
            d = '0;
            k = '0;
            for (int j = 0; j < 4; j++) begin
                if (b + j < bytes.size()) begin
                    d[31-8*j -: 8] = bytes[b+j];
                    k[3-j]         = 1'b1;
                end
            end
            exp_q.push_back({(b + 4 >= bytes.size()), k, d});
        end
    endtask

    task automatic wait_and_compare(input string name);
        int n;
        int t;
        n = exp_q.size();
        t = 0;
        while (out_q.size() < n && t < 1000) begin
            tick();
            t++;
        end
        repeat (4) tick();
        check_eq({name, "_beats"}, 64'(out_q.size()), 64'(n));
        for (int i = 0; i < n && i < out_q.size(); i++) begin
            check_eq($sformatf("%s_b%0d", name, i), 64'(out_q[i]), 64'(exp_q[i]));
        end
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        s_tdata   = '0; s_tkeep  = '0; s_tvalid  = 1'b0; s_tlast  = 1'b0; m_tready  = 1'b1;
        s8_tdata  = '0; s8_tkeep = '0; s8_tvalid = 1'b0; s8_tlast = 1'b0; m8_tready = 1'b1;
        #1;
        check_eq("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check_eq("rst_m_tdata", 64'(m_tdata), 64'(0));
        check_eq("rst_frames", 64'(frames_sent), 64'(0));
        check_eq("rst_s_tready", 64'(s_tready), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Test 1: "123456789" with MIN_FRAME=8, CRC CBF43926 spills into a 1-byte beat
        s8_tvalid = 1'b1;
        s8_tdata = 32'h31323334; s8_tkeep = 4'b1111; s8_tlast = 1'b0; tick();
        s8_tdata = 32'h35363738; s8_tkeep = 4'b1111; s8_tlast = 1'b0; tick();
        s8_tdata = 32'h39AABBCC; s8_tkeep = 4'b1000; s8_tlast = 1'b1; tick();
        s8_tvalid = 1'b0;
        for (int t = 0; t < 50 && out8_q.size() < 4; t++) tick();
        repeat (3) tick();
        check_eq("t1_beats", 64'(out8_q.size()), 64'(4));
        if (out8_q.size() >= 4) begin
            check_eq("t1_b0", 64'(out8_q[0]), 64'({1'b0, 4'b1111, 32'h31323334}));
            check_eq("t1_b1", 64'(out8_q[1]), 64'({1'b0, 4'b1111, 32'h35363738}));
            check_eq("t1_b2", 64'(out8_q[2]), 64'({1'b0, 4'b1111, 32'h392639F4}));
            check_eq("t1_b3", 64'(out8_q[3]), 64'({1'b1, 4'b1000, 32'hCB000000}));
        end
        check_eq("t1_frames", 64'(frames8_sent), 64'(1));

        // Test 2: 14-byte frame padded to 60
        make_frame(14, 0); build_expected(60); send_frame(100); wait_and_compare("t2");
        check_eq("t2_frames", 64'(frames_sent), 64'(1));

        // Test 3: 64-byte frame, no padding
        make_frame(64, 3); build_expected(60); send_frame(100); wait_and_compare("t3");
        check_eq("t3_frames", 64'(frames_sent), 64'(2));

        // Test 4: both frames back-to-back under random backpressure
        bp_en = 1'b1;
        make_frame(14, 0); build_expected(60); send_frame(100);
        make_frame(64, 3); build_expected(60); send_frame(100);
        wait_and_compare("t4");
        bp_en = 1'b0;
        tick();
        check_eq("t4_frames", 64'(frames_sent), 64'(4));

        // Test 5: reset after 5 beats of a 64-byte frame, then a clean 14-byte frame
        make_frame(64, 5); send_frame(5);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_tvalid", 64'(m_tvalid), 64'(0));
        check_eq("t5_rst_frames", 64'(frames_sent), 64'(0));
        tick(); tick();
        reset = 1'b0;
        out_q.delete();
        tick();
        make_frame(14, 0); build_expected(60); send_frame(100); wait_and_compare("t5");
        check_eq("t5_frames", 64'(frames_sent), 64'(1));

        // Test 6: 61-byte frame, last keep 1000 -> 3 FCS bytes share the last data beat
        make_frame(61, 9); build_expected(60); send_frame(100); wait_and_compare("t6");
        check_eq("t6_frames", 64'(frames_sent), 64'(2));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
